interleaver_pp_ctrl: RTL and testbench

INTERLEAVER_PP_CTRL -- requirements
Module: interleaver_pp_ctrl

---
 rtl/interleaver_pp_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_interleaver_pp_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interleaver_pp_ctrl.sv
// interleaver_pp_ctrl
// Ping-pong bank controller sitting between a bit interleaver (writer) and a
// modulator (reader). Two external RAM banks alternate: one is filled with
// NCBPS permuted writes while the other is drained sequentially.
// The RAM read port is registered; valid_out/rd_sel are aligned with its q.
// Optional feature: define PPC_OVERFLOW_DETECT_EN to build the sticky
// err_overflow detector (otherwise err_overflow is tied low).
module interleaver_pp_ctrl #(
    parameter int NCBPS = 192,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_valid,
    input  logic [AW-1:0] wr_index,
    output logic          wr_ready,
    output logic          wr_en_a,
    output logic          wr_en_b,
    output logic [AW-1:0] wr_addr,
    output logic          rd_en_a,
    output logic          rd_en_b,
    output logic [AW-1:0] rd_addr,
    output logic          rd_sel,
    input  logic          ready_in,
    output logic          valid_out,
    output logic          block_done,
    output logic          err_overflow
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    localparam logic [AW-1:0] LAST_ADDR = AW'(NCBPS - 1);

    logic [1:0]    bank_st [2];
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_cnt_q, wr_cnt_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic          rd_issued_q, rd_issued_d;   // all NCBPS reads of the bank issued
    logic          valid_q, valid_d;
    logic          sel_q, sel_d;
    logic          last_q, last_d;             // q currently holds address NCBPS-1

    logic wr_fire;
    logic consume;
    logic last_consume;
    logic b2b;
    logic rd_norm;
    logic rd_fire;
    logic rd_bank;

    // Write handshake and read issue decisions (registered state + inputs only)
    always_comb begin
        wr_ready     = ((bank_st[wr_ptr_q] == ST_EMPTY) || (bank_st[wr_ptr_q] == ST_FILL)) && !reset;
        wr_fire      = wr_valid && wr_ready;
        consume      = valid_q && ready_in;
        last_consume = consume && last_q;
        // Next bank already full: start it while the last bit leaves, no bubble
        b2b          = last_consume && (bank_st[~rd_ptr_q] == ST_FULL);
        rd_norm      = (bank_st[rd_ptr_q] == ST_DRAIN) && !rd_issued_q && (!valid_q || ready_in);
        rd_fire      = (rd_norm || b2b) && !reset;
        rd_bank      = b2b ? ~rd_ptr_q : rd_ptr_q;
    end

    // Per-bank state: EMPTY -> FILL -> FULL -> DRAIN -> EMPTY
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            localparam logic BANK_ID = 1'(gi);
            logic [1:0] st_q, st_d;

            // Next state for this bank; a fill and the other bank's release are independent
            always_comb begin
                st_d = st_q;
                if (wr_fire && (wr_ptr_q == BANK_ID))
                    st_d = (wr_cnt_q == LAST_ADDR) ? ST_FULL : ST_FILL;
                if (last_consume && (rd_ptr_q == BANK_ID))
                    st_d = ST_EMPTY;
                if ((rd_ptr_q == BANK_ID) && (st_q == ST_FULL))
                    st_d = ST_DRAIN;
                if (b2b && (rd_ptr_q != BANK_ID))
                    st_d = ST_DRAIN;
            end

            // Bank state register
            always_ff @(posedge clk) begin
                if (reset)
                    st_q <= ST_EMPTY;
                else
                    st_q <= st_d;
            end

            assign bank_st[gi] = st_q;
        end
    endgenerate

    // Write counter and write bank pointer
    always_comb begin
        wr_cnt_d = wr_cnt_q;
        wr_ptr_d = wr_ptr_q;
        if (wr_fire) begin
            if (wr_cnt_q == LAST_ADDR) begin
                wr_cnt_d = '0;
                wr_ptr_d = ~wr_ptr_q;
            end else begin
                wr_cnt_d = wr_cnt_q + AW'(1);
            end
        end
    end

    // Read address, output-valid pipeline and read bank pointer
    always_comb begin
        rd_addr_d   = rd_addr_q;
        rd_issued_d = rd_issued_q;
        valid_d     = valid_q;
        sel_d       = sel_q;
        last_d      = last_q;
        rd_ptr_d    = rd_ptr_q;
        if (consume)
            valid_d = 1'b0;
        if (last_consume) begin
            rd_ptr_d    = ~rd_ptr_q;
            rd_issued_d = 1'b0;
        end
        if (rd_fire) begin
            valid_d = 1'b1;
            sel_d   = rd_bank;
            last_d  = (rd_addr_q == LAST_ADDR);
            if (rd_addr_q == LAST_ADDR) begin
                rd_addr_d   = '0;
                rd_issued_d = 1'b1;
            end else begin
                rd_addr_d = rd_addr_q + AW'(1);
            end
        end
    end

    // Controller registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            wr_cnt_q    <= '0;
            rd_addr_q   <= '0;
            rd_issued_q <= 1'b0;
            valid_q     <= 1'b0;
            sel_q       <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_addr_q   <= rd_addr_d;
            rd_issued_q <= rd_issued_d;
            valid_q     <= valid_d;
            sel_q       <= sel_d;
            last_q      <= last_d;
        end
    end

`ifdef PPC_OVERFLOW_DETECT_EN
    logic err_q, err_d;

    // Sticky flag: writer offered a bit that had nowhere to go
    always_comb begin
        err_d = err_q || (wr_valid && !wr_ready);
    end

    // Overflow flag register, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset)
            err_q <= 1'b0;
        else
            err_q <= err_d;
    end

    assign err_overflow = err_q;
`else
    assign err_overflow = 1'b0;
`endif

    assign wr_en_a    = wr_fire && !wr_ptr_q;
    assign wr_en_b    = wr_fire && wr_ptr_q;
    assign wr_addr    = wr_index;
    assign rd_en_a    = rd_fire && !rd_bank;
    assign rd_en_b    = rd_fire && rd_bank;
    assign rd_addr    = rd_addr_q;
    assign rd_sel     = sel_q;
    assign valid_out  = valid_q;
    assign block_done = last_consume && !reset;

endmodule

// File: tb/tb_interleaver_pp_ctrl.sv
// Self-checking bench for interleaver_pp_ctrl: external RAM banks modelled
// here, random permuted block writes, scoreboard of expected output stream.
module tb_interleaver_pp_ctrl;
    localparam int N  = 192;
    localparam int AW = 8;
`ifdef PPC_OVERFLOW_DETECT_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wr_valid = 1'b0;
    logic [AW-1:0] wr_index = '0;
    logic          wr_ready;
    logic          wr_en_a, wr_en_b;
    logic [AW-1:0] wr_addr;
    logic          rd_en_a, rd_en_b;
    logic [AW-1:0] rd_addr;
    logic          rd_sel;
    logic          ready_in = 1'b0;
    logic          valid_out;
    logic          block_done;
    logic          err_overflow;

    always #5 clk = ~clk;

    interleaver_pp_ctrl #(.NCBPS(N), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .wr_valid(wr_valid), .wr_index(wr_index), .wr_ready(wr_ready),
        .wr_en_a(wr_en_a), .wr_en_b(wr_en_b), .wr_addr(wr_addr),
        .rd_en_a(rd_en_a), .rd_en_b(rd_en_b), .rd_addr(rd_addr),
        .rd_sel(rd_sel), .ready_in(ready_in), .valid_out(valid_out),
        .block_done(block_done), .err_overflow(err_overflow)
    );

    // External RAM banks with registered, hold-when-idle read ports
    logic [15:0] wr_data = '0;
    logic [15:0] ram_a [256];
    logic [15:0] ram_b [256];
    logic [15:0] q_a = '0, q_b = '0;
    wire  [15:0] q_out = rd_sel ? q_b : q_a;

    always @(posedge clk) begin
        if (wr_en_a) ram_a[wr_addr] <= wr_data;
        if (wr_en_b) ram_b[wr_addr] <= wr_data;
        if (rd_en_a) q_a <= ram_a[rd_addr];
        if (rd_en_b) q_b <= ram_b[rd_addr];
    end

    typedef struct {
        logic [15:0] data;
        logic        sel;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          blk_cnt = 0;
    int          consumed = 0;
    int          done_cnt = 0;
    int          rd_issue = 0;
    logic [15:0] stage [N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: compares every consumed bit against the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!reset) begin
                logic cons;
                logic exp_last;
                cons     = valid_out && ready_in;
                exp_last = cons && (exp_q.size() > 0) && exp_q[0].last;
                chk("block_done", block_done, exp_last);
                if (block_done) done_cnt++;
                if (valid_out && !ready_in) chk("hold_no_rd_en", rd_en_a | rd_en_b, 0);
                if (rd_en_a || rd_en_b) begin
                    chk("rd_en_onehot", rd_en_a & rd_en_b, 0);
                    chk("rd_addr", rd_addr, rd_issue);
                    rd_issue = (rd_issue + 1) % N;
                end
                if (cons) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_output", 1, 0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("q_data", q_out, e.data);
                        chk("rd_sel", rd_sel, e.sel);
                        consumed++;
                        $display("out bit data=%04h sel=%0d last=%0d", q_out, rd_sel, e.last);
                    end
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        wr_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("rst_wr_ready", wr_ready, 0);
            chk("rst_wr_en", {wr_en_a, wr_en_b}, 0);
            chk("rst_rd_en", {rd_en_a, rd_en_b}, 0);
            chk("rst_valid_out", valid_out, 0);
            chk("rst_rd_sel", rd_sel, 0);
            chk("rst_block_done", block_done, 0);
            chk("rst_err_overflow", err_overflow, 0);
            chk("rst_rd_addr", rd_addr, 0);
        end
        exp_q.delete();
        blk_cnt  = 0;
        rd_issue = 0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_wr_ready", wr_ready, 1);
        $display("reset applied");
    endtask

    // Writes n_acc accepted bits of one block in a random permuted order
    task automatic write_block(input int n_acc, input bit gaps);
        int perm [N];
        int acc = 0;
        int budget = 0;
        for (int i = 0; i < N; i++) perm[i] = i;
        for (int i = N - 1; i > 0; i--) begin
            int j;
            int t;
            j = $urandom_range(i, 0);
            t = perm[i]; perm[i] = perm[j]; perm[j] = t;
        end
        while (acc < n_acc && budget < 4000) begin
            logic a;
            @(negedge clk);
            wr_valid = gaps ? ($urandom_range(3, 0) != 0) : 1'b1;
            wr_index = AW'(perm[acc]);
            wr_data  = 16'($urandom);
            #1;
            a = wr_valid && wr_ready;
            chk("wr_en_a", wr_en_a, a && (blk_cnt % 2 == 0));
            chk("wr_en_b", wr_en_b, a && (blk_cnt % 2 == 1));
            if (a) begin
                chk("wr_addr", wr_addr, perm[acc]);
                stage[perm[acc]] = wr_data;
                acc++;
                if (acc == N) begin
                    for (int k = 0; k < N; k++) begin
                        exp_t e;
                        e.data = stage[k];
                        e.sel  = 1'(blk_cnt % 2);
                        e.last = (k == N - 1);
                        exp_q.push_back(e);
                    end
                    $display("block %0d written", blk_cnt);
                    blk_cnt++;
                end
            end
            budget++;
        end
        if (acc < n_acc) chk("write_timeout", acc, n_acc);
    endtask

    task automatic wait_drain(input bit rnd_ready);
        int budget = 0;
        while (exp_q.size() != 0 && budget < 3000) begin
            @(negedge clk);
            if (rnd_ready) ready_in = 1'($urandom_range(1, 0));
            budget++;
        end
        @(negedge clk);
        ready_in = 1'b1;
        repeat (4) @(negedge clk);
        chk("drain_remaining", exp_q.size(), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int c0;
        do_reset();

        // Single block, ready_in high: 2-cycle latency from FULL
        ready_in = 1'b1;
        d0 = done_cnt;
        write_block(N, 1'b0);
        @(negedge clk); wr_valid = 1'b0; #1;
        chk("lat_cycle1", valid_out, 0);
        @(negedge clk); #1;
        chk("lat_cycle2", valid_out, 0);
        @(negedge clk); #1;
        chk("lat_cycle3", valid_out, 1);
        wait_drain(1'b0);
        chk("t1_block_done_count", done_cnt - d0, 1);

        // Four blocks streamed; the handoff to an already-full bank is gapless
        do_reset();
        ready_in = 1'b1;
        d0 = done_cnt;
        fork
            begin
                for (int b = 0; b < 4; b++) write_block(N, 1'b0);
                @(negedge clk);
                wr_valid = 1'b0;
            end
            begin
                int gaps = 0;
                int wt = 0;
                do begin
                    @(negedge clk); #3;
                    wt++;
                end while (!valid_out && wt < 500);
                chk("t2_first_valid_seen", valid_out, 1);
                for (int i = 1; i < 2 * N; i++) begin
                    @(negedge clk); #3;
                    if (!valid_out) gaps++;
                end
                chk("t2_b2b_gaps", gaps, 0);
            end
        join
        wait_drain(1'b0);
        chk("t2_block_done_count", done_cnt - d0, 4);

        // Both banks filled with downstream stalled; output holds, writes refused
        do_reset();
        ready_in = 1'b0;
        c0 = consumed;
        write_block(N, 1'b0);
        write_block(N, 1'b0);
        begin
            logic [15:0] q0;
            @(negedge clk); wr_valid = 1'b1; #1;
            chk("t3_wr_ready_full", wr_ready, 0);
            q0 = q_out;
            repeat (5) begin
                @(negedge clk); #1;
                chk("t3_wr_ready_full", wr_ready, 0);
                chk("t3_no_wr_en", {wr_en_a, wr_en_b}, 0);
                chk("t3_valid_held", valid_out, 1);
                chk("t3_q_held", q_out, q0);
            end
            chk("t3_err_overflow", err_overflow, EXP_ERR);
        end
        @(negedge clk); wr_valid = 1'b0;
        ready_in = 1'b1;
        wait_drain(1'b0);
        chk("t3_consumed", consumed - c0, 2 * N);
        chk("t3_err_sticky", err_overflow, EXP_ERR);

        // Random downstream stalls during a drain
        do_reset();
        chk("t4_err_cleared", err_overflow, 0);
        ready_in = 1'b0;
        c0 = consumed;
        write_block(N, 1'b1);
        @(negedge clk); wr_valid = 1'b0;
        wait_drain(1'b1);
        chk("t4_consumed", consumed - c0, N);

        // Reset in the middle of a fill; only the re-filled block comes out
        do_reset();
        ready_in = 1'b1;
        write_block(100, 1'b1);
        do_reset();
        c0 = consumed;
        repeat (10) begin
            @(negedge clk); #1;
            chk("t5_no_stale_valid", valid_out, 0);
        end
        write_block(N, 1'b1);
        @(negedge clk); wr_valid = 1'b0;
        wait_drain(1'b0);
        chk("t5_consumed", consumed - c0, N);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
